// File: rtl/acsu_pipe.sv
// Viterbi add-compare-select stage: one trellis step per accepted branch-metric vector,
// saturating adds, tie-to-p0 selection and MSB-clearing renormalisation of path metrics.
module acsu_pipe #(
    parameter int unsigned NUM_ST  = 4,
    parameter int unsigned BM_W    = 2,
    parameter int unsigned PM_W    = 8,
    parameter int unsigned INIT_PM = 64,
    parameter int unsigned ST_W    = $clog2(NUM_ST)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     valid_i,
    input  logic [2*NUM_ST*BM_W-1:0] bm_i,
    output logic                     valid_o,
    output logic [NUM_ST-1:0]        dec_bits_o,
    output logic [NUM_ST*PM_W-1:0]   pm_o,
    output logic [ST_W-1:0]          best_state_o,
    output logic                     norm_o
);
    localparam int unsigned HALF = NUM_ST / 2;

    typedef logic [NUM_ST-1:0][PM_W-1:0] pm_vec_t;

    pm_vec_t                       pm_q, pm_init, pm_in, pm_sel, pm_d;
    logic [NUM_ST-1:0][PM_W:0]     c0, c1;
    logic [2*NUM_ST-1:0][BM_W-1:0] bm;
    logic [NUM_ST-1:0]             dec_d, dec_q, msb;
    logic [ST_W-1:0]               best_d, best_q;
    logic                          norm_d, norm_q, valid_q;

    assign bm = bm_i;

    always_comb begin
        for (int s = 0; s < NUM_ST; s++) begin
            pm_init[s] = (s == 0) ? '0 : PM_W'(INIT_PM);
        end
    end

    // A start pulse coinciding with a step feeds the init vector straight into the adders.
    assign pm_in = start_i ? pm_init : pm_q;

    always_comb begin
        for (int s = 0; s < NUM_ST; s++) begin
            c0[s] = {1'b0, pm_in[2*(s%HALF)]}   + (PM_W+1)'(bm[2*s]);
            c1[s] = {1'b0, pm_in[2*(s%HALF)+1]} + (PM_W+1)'(bm[2*s+1]);
            if (c0[s][PM_W]) c0[s] = {1'b0, {PM_W{1'b1}}};
            if (c1[s][PM_W]) c1[s] = {1'b0, {PM_W{1'b1}}};
            if (c1[s] < c0[s]) begin
                pm_sel[s] = c1[s][PM_W-1:0];
                dec_d[s]  = 1'b1;
            end else begin
                pm_sel[s] = c0[s][PM_W-1:0];
                dec_d[s]  = 1'b0;
            end
            msb[s] = pm_sel[s][PM_W-1];
        end
    end

    assign norm_d = &msb;

    always_comb begin
        for (int s = 0; s < NUM_ST; s++) begin
            pm_d[s] = norm_d ? {1'b0, pm_sel[s][PM_W-2:0]} : pm_sel[s];
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        best_d = '0;
        for (int s = 1; s < NUM_ST; s++) begin
            if (pm_d[s] < pm_d[best_d]) best_d = ST_W'(s);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_ST; s++) begin
                pm_q[s] <= (s == 0) ? '0 : PM_W'(INIT_PM);
            end
            dec_q   <= '0;
            best_q  <= '0;
            norm_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                pm_q   <= pm_d;
                dec_q  <= dec_d;
                best_q <= best_d;
                norm_q <= norm_d;
            end else if (start_i) begin
                pm_q <= pm_init;
            end
        end
    end

    assign valid_o      = valid_q;
    assign dec_bits_o   = dec_q;
    assign pm_o         = pm_q;
    assign best_state_o = best_q;
    assign norm_o       = norm_q;

endmodule
